// File: rtl/fft_result_reader.sv
// Streams the four FFT result banks out in bin order (0..2047) over a
// valid/ready interface, using credit-based reads into a small output FIFO.
module fft_result_reader #(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iSTART,
  input  logic signed [15:0] iDATA_RE_0,
  input  logic signed [15:0] iDATA_RE_1,
  input  logic signed [15:0] iDATA_RE_2,
  input  logic signed [15:0] iDATA_RE_3,
  output logic [8:0]         oADDR_RD,
  output logic               oRD_EN,
  output logic signed [15:0] oDATA,
  output logic [10:0]        oINDEX,
  output logic               oVALID,
  input  logic               iREADY,
  output logic               oLAST,
  output logic               oBUSY,
  output logic               oDONE
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(RD_LAT + 1);
  localparam int SW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam logic [10:0] LAST_INDEX = 11'd2047;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t state_reg, state_next;

  logic [10:0]        rd_index_reg;
  logic               rd_issue;
  logic               start_load;

  logic [RD_LAT-1:0]  pipe_valid_reg;
  logic [10:0]        pipe_index_reg [RD_LAT];
  logic [IW-1:0]      inflight;

  logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]      fifo_count_reg;
  logic [26:0]        fifo_word [FIFO_DEPTH];
  logic [26:0]        head_word;
  logic               push, pop;

  logic [SW-1:0]      occupancy;
  logic               credit_ok;

  logic [10:0]        ret_index;
  logic signed [15:0] ret_data;

  // A read may only issue if the FIFO is guaranteed to have room when it returns.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + IW'(pipe_valid_reg[i]);
    end
  end

  assign occupancy = SW'(fifo_count_reg) + SW'(inflight);
  assign credit_ok = occupancy < SW'(FIFO_DEPTH);

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rd_issue   = 1'b0;
    start_load = 1'b0;
    case (state_reg)
      IDLE: begin
        if (iSTART) begin
          state_next = READ;
          start_load = 1'b1;
        end
      end
      READ: begin
        if (credit_ok) begin
          rd_issue = 1'b1;
          if (rd_index_reg == LAST_INDEX) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (inflight == '0 && fifo_count_reg == '0) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bank-major counter: {bank, addr}; holds at 2047 instead of wrapping.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      rd_index_reg <= '0;
    end else if (start_load) begin
      rd_index_reg <= '0;
    end else if (rd_issue && rd_index_reg != LAST_INDEX) begin
      rd_index_reg <= rd_index_reg + 11'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      pipe_valid_reg <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_index_reg[i] <= '0;
      end
    end else begin
      pipe_valid_reg[0] <= rd_issue;
      pipe_index_reg[0] <= rd_index_reg;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        pipe_index_reg[i] <= pipe_index_reg[i-1];
      end
    end
  end

  assign ret_index = pipe_index_reg[RD_LAT-1];

  always_comb begin
    ret_data = iDATA_RE_0;
    case (ret_index[10:9])
      2'd0:    ret_data = iDATA_RE_0;
      2'd1:    ret_data = iDATA_RE_1;
      2'd2:    ret_data = iDATA_RE_2;
      default: ret_data = iDATA_RE_3;
    endcase
  end

  assign push = pipe_valid_reg[RD_LAT-1];
  assign pop  = (fifo_count_reg != '0) && iREADY;

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [26:0] entry_reg;
      always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
          entry_reg <= '0;
        end else if (push && wr_ptr_reg == PW'(gi)) begin
          entry_reg <= {ret_index, ret_data};
        end
      end
      assign fifo_word[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CW'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CW'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  assign head_word = fifo_word[rd_ptr_reg];

  // Outputs are forced to zero while empty so reset clears them without a clock.
  assign oVALID   = (fifo_count_reg != '0);
  assign oDATA    = oVALID ? $signed(head_word[15:0]) : 16'sd0;
  assign oINDEX   = oVALID ? head_word[26:16] : 11'd0;
  assign oLAST    = oVALID && (head_word[26:16] == LAST_INDEX);
  assign oADDR_RD = rd_index_reg[8:0];
  assign oRD_EN   = rd_issue;
  assign oBUSY    = (state_reg != IDLE);
  assign oDONE    = (state_reg == FINISH);

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench: RAM model with RD_LAT=2, transfer scoreboard, timing and reset checks.
module tb_fft_result_reader;

  logic               iCLK = 1'b0;
  logic               iRESET = 1'b0;
  logic               iSTART = 1'b0;
  logic               iREADY = 1'b0;
  logic signed [15:0] d0, d1, d2, d3;
  logic [8:0]         oADDR_RD;
  logic               oRD_EN;
  logic signed [15:0] oDATA;
  logic [10:0]        oINDEX;
  logic               oVALID, oLAST, oBUSY, oDONE;

  fft_result_reader #(.RD_LAT(2), .FIFO_DEPTH(4)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
    .iDATA_RE_0(d0), .iDATA_RE_1(d1), .iDATA_RE_2(d2), .iDATA_RE_3(d3),
    .oADDR_RD(oADDR_RD), .oRD_EN(oRD_EN), .oDATA(oDATA), .oINDEX(oINDEX),
    .oVALID(oVALID), .iREADY(iREADY), .oLAST(oLAST), .oBUSY(oBUSY), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  // Four banks sharing one address, two-cycle read latency.
  logic [15:0] ram [2048];
  logic [15:0] r1 [4];
  logic [15:0] r2 [4];
  always @(posedge iCLK) begin
    if (oRD_EN) begin
      for (int b = 0; b < 4; b++) r1[b] <= ram[b*512 + int'(oADDR_RD)];
    end
    r2 <= r1;
  end
  assign d0 = r2[0];
  assign d1 = r2[1];
  assign d2 = r2[2];
  assign d3 = r2[3];

  int  n_cmp = 0;
  int  n_fail = 0;
  bit  marker_mode = 1'b0;
  int  exp_idx, xfers, rd_issued, first_valid, done_cnt, done_at, start_cyc, max_out;
  logic [15:0] seen [2048];

  function automatic logic [15:0] exp_word(int idx, bit mk);
    if (mk && (idx == 511 || idx == 1023 || idx == 1535)) return 16'h7FFF;
    if (mk && (idx == 512 || idx == 1024 || idx == 1536)) return 16'h8000;
    return 16'(idx - 1024);
  endfunction

  function automatic logic [41:0] outs_vec();
    return {oADDR_RD, oRD_EN, oDATA, oINDEX, oVALID, oLAST, oBUSY, oDONE};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load_ram(bit mk);
    marker_mode = mk;
    for (int i = 0; i < 2048; i++) ram[i] = exp_word(i, mk);
  endtask

  task automatic monitor();
    forever begin
      @(negedge iCLK);
      if (iRESET) begin
        if (iSTART && !oBUSY) begin
          start_cyc = cyc + 1;
          exp_idx = 0; xfers = 0; rd_issued = 0; first_valid = -1;
          done_cnt = 0; done_at = -1; max_out = 0;
        end
        if (oRD_EN) rd_issued++;
        if (oVALID && first_valid < 0) first_valid = cyc - start_cyc;
        if (oVALID && iREADY) begin
          check("xfer", {36'd0, oINDEX, oDATA, oLAST},
                {36'd0, exp_idx[10:0], exp_word(exp_idx, marker_mode), (exp_idx == 2047)});
          $display("xfer idx=%0d data=%0h last=%0b", oINDEX, oDATA, oLAST);
          seen[oINDEX] = oDATA;
          exp_idx++;
          xfers++;
        end
        if (rd_issued - xfers > max_out) max_out = rd_issued - xfers;
        if (oDONE) begin
          done_cnt++;
          done_at = cyc - start_cyc;
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge iCLK); #1 iSTART = 1'b1;
    @(posedge iCLK); #1 iSTART = 1'b0;
  endtask

  task automatic wait_done(int limit, bit rnd);
    int i = 0;
    while (done_cnt == 0 && i < limit) begin
      @(posedge iCLK); #1;
      if (rnd) iREADY = ($urandom_range(0, 9) < 3);
      i++;
    end
    check("done_timeout", {63'd0, (done_cnt != 0)}, 64'd1);
    iREADY = 1'b1;
    repeat (10) @(posedge iCLK);
    #1;
  endtask

  task automatic check_run(string tag);
    check({tag, "_xfers"}, xfers, 2048);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_max_out"}, {63'd0, (max_out <= 4)}, 64'd1);
    check({tag, "_busy_end"}, {63'd0, oBUSY}, 64'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    load_ram(1'b0);
    repeat (3) @(posedge iCLK);
    #1 check("reset_outs", {22'd0, outs_vec()}, 64'd0);
    @(posedge iCLK); #1 iRESET = 1'b1;
    repeat (5) @(posedge iCLK);
    #1 check("idle_after_release", {22'd0, outs_vec()}, 64'd0);

    // Full rate with iREADY held high
    iREADY = 1'b1;
    pulse_start();
    wait_done(3000, 1'b0);
    check_run("full");
    check("first_valid_lat", first_valid, 3);
    check("done_lat", done_at, 2052);

    // Sparse iREADY
    pulse_start();
    wait_done(20000, 1'b1);
    check_run("random_ready");

    // Stalled downstream: only FIFO_DEPTH reads may issue
    iREADY = 1'b0;
    pulse_start();
    repeat (100) @(posedge iCLK);
    #1;
    check("stall_reads", rd_issued, 4);
    check("stall_valid", {63'd0, oVALID}, 64'd1);
    check("stall_index", {53'd0, oINDEX}, 64'd0);
    check("stall_data", {48'd0, oDATA}, 64'h0000_0000_0000_FC00);
    iREADY = 1'b1;
    wait_done(3000, 1'b0);
    check_run("stall");

    // Extra iSTART pulses during an unload
    pulse_start();
    repeat (8) @(posedge iCLK);
    pulse_start();
    repeat (1988) @(posedge iCLK);
    pulse_start();
    wait_done(3000, 1'b0);
    check_run("extra_start");

    // Asynchronous reset at transfer 700, then a clean restart
    pulse_start();
    for (int i = 0; i < 3000 && xfers < 700; i++) begin
      @(posedge iCLK); #1;
    end
    check("reached_700", {63'd0, (xfers >= 700)}, 64'd1);
    #1 iRESET = 1'b0;
    #1 check("async_reset_outs", {22'd0, outs_vec()}, 64'd0);
    check("abort_no_done", done_cnt, 0);
    @(posedge iCLK); #1 iRESET = 1'b1;
    repeat (3) @(posedge iCLK);
    #1 check("post_abort_idle", {22'd0, outs_vec()}, 64'd0);
    pulse_start();
    wait_done(3000, 1'b0);
    check_run("restart");
    check("restart_done_lat", done_at, 2052);

    // Bank boundaries carry distinct markers
    load_ram(1'b1);
    pulse_start();
    wait_done(3000, 1'b0);
    check_run("markers");
    check("m511",  {48'd0, seen[511]},  64'h7FFF);
    check("m512",  {48'd0, seen[512]},  64'h8000);
    check("m1023", {48'd0, seen[1023]}, 64'h7FFF);
    check("m1024", {48'd0, seen[1024]}, 64'h8000);
    check("m1535", {48'd0, seen[1535]}, 64'h7FFF);
    check("m1536", {48'd0, seen[1536]}, 64'h8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_result_reader.md
FFT_RESULT_READER -- requirements
Module: fft_result_reader

Interface
REQ-001 Parameter RD_LAT, default 2: cycles from oADDR_RD/oRD_EN to valid iDATA_RE_n.
REQ-002 Parameter FIFO_DEPTH, default 4: output buffer entries; SHALL be >= RD_LAT+2.
REQ-003 iCLK  in  1  sole clock; all logic on rising edge.
REQ-004 iRESET  in  1  asynchronous, active-low reset.
REQ-005 iSTART  in  1  single-cycle unload request, issued after FFT oRDY.
REQ-006 iDATA_RE_0..iDATA_RE_3  in  16 each  signed read data from RAM banks 0..3.
REQ-007 oADDR_RD  out  9  read address, driven to all four banks.
REQ-008 oRD_EN  out  1  read issued this cycle.
REQ-009 oDATA  out  16  signed result sample.
REQ-010 oINDEX  out  11  bin index = bank*512 + addr.
REQ-011 oVALID  out  1  oDATA/oINDEX/oLAST valid.
REQ-012 iREADY  in  1  downstream accepts when oVALID&iREADY.
REQ-013 oLAST  out  1  high with index 2047.
REQ-014 oBUSY  out  1  unload in progress.
REQ-015 oDONE  out  1  one-cycle pulse after final transfer.

Function
REQ-016 FSM states: IDLE, READ, DRAIN, FINISH.
REQ-017 IDLE->READ on iSTART; iSTART SHALL be ignored in any other state.
REQ-018 READ: issue reads bank-major, bank 0 addr 0..511, then banks 1, 2, 3; 2048 reads total.
REQ-019 Read issue condition: fifo_count + inflight < FIFO_DEPTH; otherwise oRD_EN=0 and address held.
REQ-020 inflight counts issued reads not yet written to FIFO; range 0..RD_LAT.
REQ-021 Bank tag and address SHALL travel in an RD_LAT-stage pipeline alongside each read; returned data selected from iDATA_RE_[tag].
REQ-022 READ->DRAIN on the cycle the 2048th read issues.
REQ-023 DRAIN->FINISH when inflight=0, FIFO empty, and the last transfer completes.
REQ-024 FINISH: oDONE=1 for exactly one cycle; next state IDLE.
REQ-025 oBUSY=1 in READ, DRAIN, FINISH; 0 in IDLE.
REQ-026 FIFO SHALL never overflow; the credit rule guarantees room for every returning read.
REQ-027 oVALID = FIFO non-empty; head entry stable while oVALID & !iREADY.
REQ-028 Simultaneous FIFO push and pop SHALL keep count unchanged.
REQ-029 Output order strictly increasing oINDEX 0..2047, no gaps or duplicates, under any iREADY pattern.
REQ-030 oLAST SHALL be asserted only on the index 2047 entry.
REQ-031 Data passes unmodified: oDATA equals the RAM word bit-for-bit.
REQ-032 Full-rate: with iREADY held 1, one transfer per cycle after the first; first oVALID RD_LAT+1 cycles after the iSTART-capturing edge; oDONE RD_LAT+2050 cycles after it.
REQ-033 Address counter wraps 511->0 with bank increment; no wrap after bank 3.

Reset
REQ-034 iRESET low SHALL immediately set: state IDLE, oADDR_RD=0, oRD_EN=0, oVALID=0, oDATA=0, oINDEX=0, oLAST=0, oBUSY=0, oDONE=0, FIFO empty, inflight=0.
REQ-035 Reset mid-unload aborts the transfer with no oDONE; the next iSTART restarts from index 0.
REQ-036 After release, no output SHALL change until iSTART.

Verification
REQ-037 RAM model (RD_LAT=2) holds bank b, addr a = b*512+a-1024; iREADY=1, iSTART pulse -> 2048 transfers, oDATA=oINDEX-1024, oLAST at 2047, oDONE at cycle 2052.
REQ-038 Same data, iREADY random 30% duty -> identical in-order sequence, FIFO count never > 4, no lost or duplicate index.
REQ-039 iREADY=0 for 100 cycles after start -> exactly 4 reads issued, oVALID held with oINDEX=0, then resumes correctly on iREADY=1.
REQ-040 Extra iSTART pulses at cycles 10 and 2000 of an unload -> ignored; single 0..2047 sequence and single oDONE.
REQ-041 iRESET low at transfer 700 -> all outputs 0 asynchronously; new iSTART -> full sequence from index 0.
REQ-042 Bank boundary: entries 511/512, 1023/1024 and 1535/1536 sourced from the correct bank (distinct marker values 0x7FFF/0x8000).
